// File: rtl/updown_dir_ctrl.sv
// Direction controller for the ripple up/down counter.
// Filters count feedback, debounces a toggle button, ping-pongs at limits.
module updown_dir_ctrl #(
  parameter int WIDTH           = 4,
  parameter int MIN_VAL         = 0,
  parameter int MAX_VAL         = 15,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] count_in,
  output logic             up,
  output logic [WIDTH-1:0] count_sync,
  output logic             dir_change,
  output logic             btn_event
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [WIDTH-1:0] MINV  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VAL);
  localparam logic [DW-1:0]    DLAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    S_UP,
    S_DOWN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic             b1;
  logic             b2;
  logic             deb;
  logic [DW-1:0]    dcnt;
  logic             at_max;
  logic             at_min;
  logic             flip;

  assign at_max = auto_en && (count_sync == MAXV);
  assign at_min = auto_en && (count_sync == MINV);
  // Each state only watches its own limit, so a held limit never re-toggles.
  assign flip   = btn_event ||
                  ((state == S_UP) ? at_max : at_min);

  assign up = (state == S_UP);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= '0;
      s2         <= '0;
      count_sync <= '0;
    end else begin
      s1 <= count_in;
      s2 <= s1;
      if (s1 == s2)
        count_sync <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b1        <= 1'b0;
      b2        <= 1'b0;
      deb       <= 1'b0;
      dcnt      <= '0;
      btn_event <= 1'b0;
    end else begin
      b1        <= btn;
      b2        <= b1;
      btn_event <= 1'b0;
      if (b2 == deb) begin
        dcnt <= '0;
      end else if (dcnt == DLAST) begin
        deb       <= b2;
        dcnt      <= '0;
        btn_event <= b2;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_UP;
      dir_change <= 1'b0;
    end else begin
      dir_change <= flip;
      if (flip)
        state <= (state == S_UP) ? S_DOWN : S_UP;
    end
  end

endmodule
